result_writeback: RTL and testbench
===================================

# result_writeback

Downstream drain stage of the systolic array. Accepts one result row-vector per handshake from the PE matrix result columns, buffers up to DEPTH vectors, and serializes them into single-element writes to the shared data memory. For an n×n product, element (row r, col c) is written at addr_C + r·n + c. Pulses `done` after the last write so the controller can return to idle.

## Interface
- `N`, 4: array dimension; width of the result vector.
- `WIDTH`, 16: signed element width.
- `DEPTH`, 2: vector FIFO depth, ≥1.
- `ADDR_W`, 12: memory address width.

- `clk`  in  1  system clock; all state updates on rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `start`  in  1  begin a drain job; samples `addr_C` and `n`.
- `addr_C`  in  ADDR_W  base address of result matrix C.
- `n`  in  4  active dimension; 0 = empty job; values >N clamp to N.
- `col_valid`  in  1  `result_col` holds a valid row-vector.
- `result_col`  in  N×WIDTH signed  row-vector; element j = column j.
- `col_ready`  out  1  vector accepted on the edge where `col_valid && col_ready`.
- `mem_write`  out  1  write strobe, one element per cycle.
- `mem_addr`  out  ADDR_W  write address.
- `mem_data`  out  WIDTH signed  write data.
- `busy`  out  1  job in progress.
- `done`  out  1  one-cycle completion pulse.

## Operation
- States: IDLE, RUN, DONE.
- IDLE: `col_ready`=0, and `col_valid` is ignored. When `start`=1, latch `base`=addr_C, `nn`=min(n,N), clear `rows_in`, `row_out`, `col_out`, and the FIFO, then go to RUN.
- RUN:
  - `col_ready` = (fifo_count < DEPTH) && (rows_in < nn). It is registered-state-derived only and never depends on `col_valid`.
  - On accept, push `result_col` and increment `rows_in`.
  - Drain: while the FIFO is non-empty, each cycle drive element `col_out` of the head vector. Address = base + row_out·nn + col_out, modulo 2^ADDR_W (wraps, no error).
  - After element nn−1 of a vector, pop it, increment `row_out`, and reset `col_out` to 0. Elements j ≥ nn are never written.
  - When `row_out` reaches nn with no write pending, go to DONE. If nn=0, go to DONE on the first RUN cycle.
- DONE: `done`=1, `busy`=0, `mem_write`=0 for one cycle, then IDLE.
- `start` while in RUN or DONE is ignored.
- Push and pop may occur on the same edge, and the count is then unchanged. A push when the FIFO is full cannot occur, because `col_ready`=0.
- Data passes through unmodified, with no arithmetic on values. Full-scale negative values (−2^(WIDTH−1)) are preserved.

## Timing
- `busy`=1 from the edge after `start` is sampled, through the last write cycle.
- All `mem_*` outputs are registered and held stable for the full cycle. Memory samples them on the falling edge of the same cycle.
- Vector accepted at edge k with the drain idle: element j is driven after edge k+1+j, with `mem_write`=1.
- If the drain is busy, a vector waits in the FIFO and its element 0 follows the previous vector's last element on the next cycle, with no bubble.
- Sustained throughput: one element per cycle, so one vector per nn cycles.
- `done` rises on the edge after the last write.
- Empty job (n=0): `start` sampled at edge t gives `done` after edge t+2, with no writes.
- When `mem_write`=0, `mem_addr` and `mem_data` hold their last value.
- Reset:
  - All outputs are 0 (`col_ready`, `mem_write`, `mem_addr`, `mem_data`, `busy`, `done`), the state is IDLE, and the FIFO and counters are cleared.
  - Mid-job assertion aborts immediately, and no further writes are issued.
  - After deassertion the block waits in IDLE for a new `start`.

## Test plan
- n=2, addr_C=0x100, vectors [1,2,x,x] then [3,4,x,x] offered back-to-back → writes on 4 consecutive cycles: 0x100=1, 0x101=2, 0x102=3, 0x103=4. `done` one cycle later, then IDLE.
- n=4, DEPTH=2, `col_valid` held high with vectors [10..13], [20..23], [30..33], [40..43] → `col_ready` drops after 2 accepts and reasserts on each pop. 16 writes at 0x000–0x00F on consecutive cycles with no gaps. `col_ready`=0 after the 4th accept.
- Wrap-around: addr_C=0xFFE, n=2, vectors [5,6], [7,8] → writes 0xFFE=5, 0xFFF=6, 0x000=7, 0x001=8.
- Sign and clamping: n=9 clamps to 4. Vector [−32768, 32767, −1, 0] → written values identical. A 5th vector is never accepted.
- Reset mid-job: assert `rst` after the 3rd write of an n=4 job → all outputs 0 asynchronously and no further writes. A new `start` with n=1 and [7] → a single write of 7 at addr_C.
- n=0 `start` → `done` two cycles after `start`, zero writes. `start` pulsed again during RUN of an n=2 job → ignored, exactly 4 writes.

Source files
------------

// File: rtl/result_writeback.sv
// result_writeback: drains row-vectors from the systolic array into a small
// FIFO and serializes them into one-element-per-cycle memory writes.
// Element (r,c) of an nn x nn result lands at base + r*nn + c (mod 2^ADDR_W).
module result_writeback #(
  parameter int N      = 4,
  parameter int WIDTH  = 16,
  parameter int DEPTH  = 2,
  parameter int ADDR_W = 12
) (
  input  logic                        i_clk,
  input  logic                        i_rst,
  input  logic                        i_start,
  input  logic [ADDR_W-1:0]           i_addr_C,
  input  logic [3:0]                  i_n,
  input  logic                        i_col_valid,
  input  logic [N-1:0][WIDTH-1:0]     i_result_col,
  output logic                        o_col_ready,
  output logic                        o_mem_write,
  output logic [ADDR_W-1:0]           o_mem_addr,
  output logic signed [WIDTH-1:0]     o_mem_data,
  output logic                        o_busy,
  output logic                        o_done
);

  localparam int CW   = $clog2(N + 1);
  localparam int COLW = (N > 1) ? $clog2(N) : 1;
  localparam int PW   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int QW   = $clog2(DEPTH + 1);

  localparam logic [QW-1:0] DEPTH_Q = QW'(DEPTH);
  localparam logic [3:0]    N_MAX   = 4'(N);
  localparam logic [CW-1:0] N_CW    = CW'(N);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t                     r_state, w_state_nxt;
  logic [ADDR_W-1:0]          r_base;
  logic [CW-1:0]              r_nn;
  logic [CW-1:0]              r_rows_in;
  logic [CW-1:0]              r_row_out;
  logic [COLW-1:0]            r_col;
  logic [ADDR_W-1:0]          r_elem;     // elements written so far = r_row_out*nn + r_col
  logic [QW-1:0]              r_cnt;
  logic [PW-1:0]              r_wr, r_rd;
  logic                       r_fin;      // every row has been issued; current cycle is the last
  logic                       r_mem_write;
  logic [ADDR_W-1:0]          r_mem_addr;
  logic [WIDTH-1:0]           r_mem_data;
  logic [N-1:0][WIDTH-1:0]    r_fifo [DEPTH];

  logic                       w_run;
  logic                       w_push;
  logic                       w_drain;
  logic                       w_last;
  logic [CW-1:0]              w_row_nxt;
  logic [CW-1:0]              w_nn_in;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  assign w_run       = (r_state == S_RUN);
  assign o_col_ready = w_run && (r_cnt < DEPTH_Q) && (r_rows_in < r_nn);
  assign w_push      = o_col_ready && i_col_valid;
  assign w_drain     = w_run && (r_cnt != '0);
  assign w_last      = w_drain && (CW'(r_col) == r_nn - CW'(1));
  assign w_row_nxt   = r_row_out + CW'(w_last);
  assign w_nn_in     = (i_n > N_MAX) ? N_CW : CW'(i_n);

  assign o_busy      = w_run;
  assign o_done      = (r_state == S_DONE);
  assign o_mem_write = r_mem_write;
  assign o_mem_addr  = r_mem_addr;
  assign o_mem_data  = r_mem_data;

  // State register
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) r_state <= S_IDLE;
    else       r_state <= w_state_nxt;
  end

  // Next-state: RUN ends one cycle after the final element has been issued
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (i_start) w_state_nxt = S_RUN;
      S_RUN:   if (r_fin)   w_state_nxt = S_DONE;
      S_DONE:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Vector storage; validity is tracked by the pointers/count, so no reset
  always_ff @(posedge i_clk) begin
    if (w_push) r_fifo[r_wr] <= i_result_col;
  end

  // Job setup, FIFO bookkeeping and the registered write port
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_base      <= '0;
      r_nn        <= '0;
      r_rows_in   <= '0;
      r_row_out   <= '0;
      r_col       <= '0;
      r_elem      <= '0;
      r_cnt       <= '0;
      r_wr        <= '0;
      r_rd        <= '0;
      r_fin       <= 1'b0;
      r_mem_write <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_data  <= '0;
    end else if (r_state == S_IDLE) begin
      r_mem_write <= 1'b0;
      if (i_start) begin
        r_base    <= i_addr_C;
        r_nn      <= w_nn_in;
        r_rows_in <= '0;
        r_row_out <= '0;
        r_col     <= '0;
        r_elem    <= '0;
        r_cnt     <= '0;
        r_wr      <= '0;
        r_rd      <= '0;
        r_fin     <= 1'b0;
      end
    end else if (w_run) begin
      if (w_push) begin
        r_wr      <= ptr_inc(r_wr);
        r_rows_in <= r_rows_in + CW'(1);
      end
      if (w_drain) begin
        r_mem_write <= 1'b1;
        r_mem_addr  <= r_base + r_elem;
        r_mem_data  <= r_fifo[r_rd][r_col];
        r_elem      <= r_elem + ADDR_W'(1);
        if (w_last) begin
          r_col     <= '0;
          r_rd      <= ptr_inc(r_rd);
          r_row_out <= w_row_nxt;
        end else begin
          r_col     <= r_col + COLW'(1);
        end
      end else begin
        r_mem_write <= 1'b0;
      end
      r_cnt <= r_cnt + QW'(w_push) - QW'(w_last);
      r_fin <= (w_row_nxt == r_nn);
    end else begin
      r_mem_write <= 1'b0;
    end
  end

endmodule

// File: tb/tb_result_writeback.sv
// Randomized bench for result_writeback: each job's expected write stream is
// built from the matrix layout (base + r*nn + c, element c of row r) and the
// observed writes, handshakes and done timing are compared against it.
module tb_result_writeback;

  localparam int N  = 4;
  localparam int W  = 16;
  localparam int D  = 2;
  localparam int AW = 12;

  typedef logic [N-1:0][W-1:0] vec_t;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic [AW-1:0] addr_c = '0;
  logic [3:0]    n = '0;
  logic          col_valid = 1'b0;
  vec_t          rcol = '0;
  logic          col_ready, mem_write, busy, done;
  logic [AW-1:0] mem_addr;
  logic [W-1:0]  mem_data;

  int cyc = 0;
  int n_chk = 0;
  int n_fail = 0;
  vec_t vq[$];

  result_writeback #(.N(N), .WIDTH(W), .DEPTH(D), .ADDR_W(AW)) dut (
    .i_clk(clk), .i_rst(rst), .i_start(start), .i_addr_C(addr_c), .i_n(n),
    .i_col_valid(col_valid), .i_result_col(rcol), .o_col_ready(col_ready),
    .o_mem_write(mem_write), .o_mem_addr(mem_addr), .o_mem_data(mem_data),
    .o_busy(busy), .o_done(done)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic vec_t mkvec(input int a, input int b, input int c, input int d);
    vec_t v;
    v[0] = a[W-1:0]; v[1] = b[W-1:0]; v[2] = c[W-1:0]; v[3] = d[W-1:0];
    return v;
  endfunction

  function automatic vec_t rand_vec();
    vec_t v;
    for (int j = 0; j < N; j++) v[j] = W'($urandom);
    return v;
  endfunction

  task automatic chk_outs_zero(input string tag);
    chk({tag, "_ready"}, col_ready, 0);
    chk({tag, "_wr"},    mem_write, 0);
    chk({tag, "_addr"},  mem_addr,  0);
    chk({tag, "_data"},  mem_data,  0);
    chk({tag, "_busy"},  busy,      0);
    chk({tag, "_done"},  done,      0);
  endtask

  // Asynchronous reset mid-cycle, then confirm the block stays quiet in IDLE
  task automatic do_abort();
    #2 rst = 1'b1;
    #1 chk_outs_zero("abort_rst");
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    col_valid = 1'b1;
    rcol = rand_vec();
    repeat (6) begin
      @(negedge clk);
      chk("post_abort_wr",    mem_write, 0);
      chk("post_abort_busy",  busy,      0);
      chk("post_abort_ready", col_ready, 0);
    end
    col_valid = 1'b0;
  endtask

  // One drain job: vectors come from vq in order, offered continuously (hold)
  // or with random gaps. Called and returning on a falling edge.
  task automatic run_job(input logic [AW-1:0] base, input int nval, input bit hold,
                         input bit midstart, input int abort_after);
    int nn;
    logic [AW-1:0] exp_addr[$];
    logic [W-1:0]  exp_data[$];
    int wr, acc, first_acc, first_wr, last_wr, done_cyc, done_cnt, s_cyc, vi;
    bit fin, gap;
    nn = (nval > N) ? N : nval;
    wr = 0; acc = 0; first_acc = -1; first_wr = -1; last_wr = -1;
    done_cyc = -1; done_cnt = 0; vi = 0; fin = 1'b0; gap = 1'b0;
    for (int r = 0; r < nn; r++)
      for (int c = 0; c < nn; c++) begin
        exp_addr.push_back(AW'((int'(base) + r * nn + c) % (1 << AW)));
        exp_data.push_back(vq[r][c]);
      end

    addr_c = base; n = nval[3:0]; start = 1'b1; s_cyc = cyc;
    @(negedge clk);
    start = 1'b0; addr_c = AW'($urandom); n = 4'($urandom);
    chk("busy_after_start", busy, 1);

    for (int k = 0; k < 200 && !fin; k++) begin
      if (mem_write) begin
        if (wr < exp_addr.size()) begin
          chk("wr_addr", mem_addr, exp_addr[wr]);
          chk("wr_data", mem_data, exp_data[wr]);
        end
        if (first_wr < 0) first_wr = cyc;
        else if (cyc != last_wr + 1) gap = 1'b1;
        last_wr = cyc;
        wr++;
        if (abort_after > 0 && wr == abort_after) begin
          do_abort();
          return;
        end
      end
      if (done_cyc >= 0) begin
        chk("done_one_cycle", done, 0);
        chk("idle_ready_low", col_ready, 0);
        fin = 1'b1;
      end else if (done) begin
        done_cnt++;
        done_cyc = cyc;
        chk("done_busy_low", busy, 0);
        chk("done_no_write", mem_write, 0);
      end
      // drive the next cycle's inputs
      if (midstart && k == 3) begin
        start = 1'b1; addr_c = AW'($urandom); n = 4'($urandom_range(1, 15));
      end else begin
        start = 1'b0;
      end
      col_valid = (vi < vq.size()) && (hold || ($urandom_range(0, 1) == 1));
      rcol = (vi < vq.size()) ? vq[vi] : rand_vec();
      if (col_valid && col_ready) begin
        acc++;
        vi++;
        if (first_acc < 0) first_acc = cyc;
      end
      @(negedge clk);
    end
    col_valid = 1'b0;
    start = 1'b0;

    chk("job_finished", fin, 1);
    chk("n_writes", wr, exp_addr.size());
    chk("n_accepts", acc, nn);
    chk("done_pulses", done_cnt, 1);
    if (nn > 0) begin
      chk("first_wr_latency", first_wr - first_acc, 2);
      chk("done_after_last", done_cyc - last_wr, 1);
      if (hold) chk("no_gaps", gap, 0);
    end else begin
      chk("empty_done_latency", done_cyc - s_cyc, 3);
    end
  endtask

  initial begin
    logic [AW-1:0] b;
    int nv;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    chk_outs_zero("reset");
    rst = 1'b0;
    @(negedge clk);

    // n=2 back-to-back
    vq.delete();
    vq.push_back(mkvec(1, 2, 'h55, 'h66)); vq.push_back(mkvec(3, 4, 'h77, 'h88));
    vq.push_back(rand_vec());
    run_job(12'h100, 2, 1'b1, 1'b0, 0);

    // n=4 full rate, FIFO backpressure
    vq.delete();
    for (int i = 1; i <= 5; i++) vq.push_back(mkvec(i*10, i*10+1, i*10+2, i*10+3));
    run_job(12'h000, 4, 1'b1, 1'b0, 0);

    // address wrap
    vq.delete();
    vq.push_back(mkvec(5, 6, 0, 0)); vq.push_back(mkvec(7, 8, 0, 0)); vq.push_back(rand_vec());
    run_job(12'hFFE, 2, 1'b1, 1'b0, 0);

    // clamp n=9 -> 4, full-scale values, 5th vector refused
    vq.delete();
    vq.push_back(mkvec(-32768, 32767, -1, 0));
    for (int i = 0; i < N; i++) vq.push_back(rand_vec());
    run_job(12'h234, 9, 1'b1, 1'b0, 0);

    // reset after 3rd write, then a fresh n=1 job
    vq.delete();
    for (int i = 0; i < N + 1; i++) vq.push_back(rand_vec());
    run_job(12'h040, 4, 1'b1, 1'b0, 3);
    vq.delete();
    vq.push_back(mkvec(7, 0, 0, 0)); vq.push_back(rand_vec());
    run_job(12'h3A0, 1, 1'b1, 1'b0, 0);

    // empty job, then start ignored during RUN
    run_job(12'h123, 0, 1'b1, 1'b0, 0);
    vq.delete();
    for (int i = 0; i < N + 1; i++) vq.push_back(rand_vec());
    run_job(12'h500, 2, 1'b1, 1'b1, 0);

    // random jobs
    for (int j = 0; j < 24; j++) begin
      vq.delete();
      for (int i = 0; i < N + 1; i++) vq.push_back(rand_vec());
      b = AW'($urandom);
      nv = $urandom_range(0, 15);
      run_job(b, nv, ($urandom_range(0, 1) == 1), (nv >= 2) && ($urandom_range(0, 1) == 1), 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
